// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
// Alignment helper is only referenced when DMEM_MISALIGN_CHECK_EN is defined.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LD_ADDR = 2'd1,
    LD_DATA = 2'd2,
    ST_WR   = 2'd3
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  localparam logic GRANT_LD = 1'b0;
  localparam logic GRANT_ST = 1'b1;

  // True when the access cannot be issued as a single naturally aligned beat.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lsb);
    logic bad;
    bad = 1'b0;
    case (size)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = lsb[0];
      SIZE_WORD: bad = (lsb != 2'b00);
      SIZE_RSVD: bad = 1'b1;
      default:   bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin picker: bit 0 is the load unit, bit 1 the store unit.
// On a tie the requester that was not granted last wins.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (req == 2'b11) begin
      grant = (last_grant == GRANT_ST) ? 2'b01 : 2'b10;
    end else begin
      grant = req;
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares one synchronous data-memory port between the load and store units.
// Optional alignment checking is enabled with `define DMEM_MISALIGN_CHECK_EN.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [1:0]        ld_size,
  output logic              ld_done,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              ld_err,
  input  logic              st_req,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [1:0]        st_size,
  input  logic [DATA_W-1:0] st_wdata,
  input  logic [3:0]        st_wstrb,
  output logic              st_done,
  output logic              st_err,
  output logic              mem_en,
  output logic              mem_rw_mode,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_pc
);

  state_t            state_reg;
  logic              last_grant_reg;
  logic              ld_done_reg;
  logic              ld_err_reg;
  logic              st_done_reg;
  logic              st_err_reg;
  logic              mem_en_reg;
  logic              mem_rw_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [DATA_W-1:0] mem_wdata_reg;
  logic [3:0]        mem_wstrb_reg;

  logic [1:0] grant;
  logic       ld_bad;
  logic       st_bad;

  rr_arb2 u_rr_arb2 (
    .req        ({st_req, ld_req}),
    .last_grant (last_grant_reg),
    .grant      (grant)
  );

`ifdef DMEM_MISALIGN_CHECK_EN
  assign ld_bad = misaligned(ld_size, ld_addr[1:0]);
  assign st_bad = misaligned(st_size, st_addr[1:0]);
`else
  // Sizes only matter to the alignment check; memory sees raw addresses.
  logic unused_size;
  assign unused_size = ^{ld_size, st_size};
  assign ld_bad = 1'b0;
  assign st_bad = 1'b0;
`endif

  // Fields for the granted request are captured straight into the memory-side
  // registers, so later request changes cannot disturb an access in flight.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_reg      <= IDLE;
      last_grant_reg <= GRANT_ST;
      ld_done_reg    <= 1'b0;
      ld_err_reg     <= 1'b0;
      st_done_reg    <= 1'b0;
      st_err_reg     <= 1'b0;
      mem_en_reg     <= 1'b0;
      mem_rw_reg     <= MEM_READ;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
      mem_wstrb_reg  <= 4'b0000;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant[0]) begin
            last_grant_reg <= GRANT_LD;
            if (ld_bad) begin
              ld_done_reg <= 1'b1;
              ld_err_reg  <= 1'b1;
              state_reg   <= LD_DATA;
            end else begin
              mem_en_reg   <= 1'b1;
              mem_rw_reg   <= MEM_READ;
              mem_addr_reg <= ld_addr;
              state_reg    <= LD_ADDR;
            end
          end else if (grant[1]) begin
            last_grant_reg <= GRANT_ST;
            st_done_reg    <= 1'b1;
            state_reg      <= ST_WR;
            if (st_bad) begin
              st_err_reg <= 1'b1;
            end else begin
              mem_en_reg    <= 1'b1;
              mem_rw_reg    <= MEM_WRITE;
              mem_addr_reg  <= st_addr;
              mem_wdata_reg <= st_wdata;
              mem_wstrb_reg <= st_wstrb;
            end
          end
        end
        LD_ADDR: begin
          mem_en_reg   <= 1'b0;
          mem_addr_reg <= '0;
          ld_done_reg  <= 1'b1;
          state_reg    <= LD_DATA;
        end
        LD_DATA: begin
          ld_done_reg <= 1'b0;
          ld_err_reg  <= 1'b0;
          state_reg   <= IDLE;
        end
        ST_WR: begin
          mem_en_reg    <= 1'b0;
          mem_rw_reg    <= MEM_READ;
          mem_addr_reg  <= '0;
          mem_wdata_reg <= '0;
          mem_wstrb_reg <= 4'b0000;
          st_done_reg   <= 1'b0;
          st_err_reg    <= 1'b0;
          state_reg     <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign ld_done     = ld_done_reg;
  assign ld_err      = ld_err_reg;
  assign ld_rdata    = ld_done_reg ? mem_rdata : '0;
  assign st_done     = st_done_reg;
  assign st_err      = st_err_reg;
  assign mem_en      = mem_en_reg;
  assign mem_rw_mode = mem_rw_reg;
  assign mem_addr    = mem_addr_reg;
  assign mem_wdata   = mem_wdata_reg;
  assign mem_wstrb   = mem_wstrb_reg;

  // Reset forces the stall low even while requesters still hold their requests.
  assign stall_pc = i_rst & (ld_req | st_req | (state_reg != IDLE));

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed self-checking bench for dmem_port_arbiter with a small strobed memory model.
// Misalignment expectations follow whether DMEM_MISALIGN_CHECK_EN is defined.
module tb_dmem_port_arbiter;

  logic        clk;
  logic        i_rst;
  logic        ld_req;
  logic [31:0] ld_addr;
  logic [1:0]  ld_size;
  logic        ld_done;
  logic [31:0] ld_rdata;
  logic        ld_err;
  logic        st_req;
  logic [31:0] st_addr;
  logic [1:0]  st_size;
  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;
  logic        st_done;
  logic        st_err;
  logic        mem_en;
  logic        mem_rw_mode;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        stall_pc;

  int total;
  int bad;

  logic [31:0] tmem [0:255];

  dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .ld_req      (ld_req),
    .ld_addr     (ld_addr),
    .ld_size     (ld_size),
    .ld_done     (ld_done),
    .ld_rdata    (ld_rdata),
    .ld_err      (ld_err),
    .st_req      (st_req),
    .st_addr     (st_addr),
    .st_size     (st_size),
    .st_wdata    (st_wdata),
    .st_wstrb    (st_wstrb),
    .st_done     (st_done),
    .st_err      (st_err),
    .mem_en      (mem_en),
    .mem_rw_mode (mem_rw_mode),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wstrb   (mem_wstrb),
    .mem_rdata   (mem_rdata),
    .stall_pc    (stall_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory: read data appears the cycle after the address.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_rw_mode) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_wstrb[b]) tmem[mem_addr[9:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
        end
      end else begin
        mem_rdata <= tmem[mem_addr[9:2]];
      end
    end
  end

  task automatic test_reset();
    i_rst = 1'b0;
    #1;
    total++;
    if (mem_en !== 1'b0 || ld_done !== 1'b0 || st_done !== 1'b0 || stall_pc !== 1'b0 || mem_addr !== 32'h0) begin
      bad++;
      $display("FAIL reset_outputs: mem_en=%b ld_done=%b st_done=%b stall=%b addr=%h required all zero",
               mem_en, ld_done, st_done, stall_pc, mem_addr);
    end
    @(negedge clk);
    @(negedge clk);
    i_rst = 1'b1;
    @(negedge clk);
    total++;
    if (stall_pc !== 1'b0 || mem_en !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle: stall=%b mem_en=%b required 0 0", stall_pc, mem_en);
    end
    $display("reset: done");
  endtask

  task automatic test_single_load();
    tmem[64] = 32'hDEADBEEF;
    ld_addr = 32'h100; ld_size = 2'b10; ld_req = 1'b1;
    #1;
    total++;
    if (stall_pc !== 1'b1 || mem_en !== 1'b0) begin
      bad++;
      $display("FAIL load_c0: stall=%b mem_en=%b required 1 0", stall_pc, mem_en);
    end
    @(negedge clk);
    total++;
    if (mem_en !== 1'b1 || mem_rw_mode !== 1'b0 || mem_addr !== 32'h100 || mem_wstrb !== 4'h0 || ld_done !== 1'b0 || stall_pc !== 1'b1) begin
      bad++;
      $display("FAIL load_c1: en=%b rw=%b addr=%h wstrb=%h done=%b stall=%b required 1 0 100 0 0 1",
               mem_en, mem_rw_mode, mem_addr, mem_wstrb, ld_done, stall_pc);
    end
    @(negedge clk);
    total++;
    if (ld_done !== 1'b1 || ld_rdata !== 32'hDEADBEEF || mem_en !== 1'b0 || ld_err !== 1'b0 || stall_pc !== 1'b1) begin
      bad++;
      $display("FAIL load_c2: done=%b rdata=%h en=%b err=%b stall=%b required 1 deadbeef 0 0 1",
               ld_done, ld_rdata, mem_en, ld_err, stall_pc);
    end
    ld_req = 1'b0;
    @(negedge clk);
    total++;
    if (ld_done !== 1'b0 || stall_pc !== 1'b0) begin
      bad++;
      $display("FAIL load_c3: done=%b stall=%b required 0 0", ld_done, stall_pc);
    end
    $display("single_load: addr=100 rdata=%h", 32'hDEADBEEF);
  endtask

  task automatic test_single_store();
    int en_count;
    st_addr = 32'h204; st_size = 2'b10; st_wdata = 32'h12345678; st_wstrb = 4'hF; st_req = 1'b1;
    @(negedge clk);
    total++;
    if (mem_en !== 1'b1 || mem_rw_mode !== 1'b1 || mem_addr !== 32'h204 || mem_wdata !== 32'h12345678 ||
        mem_wstrb !== 4'hF || st_done !== 1'b1 || st_err !== 1'b0) begin
      bad++;
      $display("FAIL store_c1: en=%b rw=%b addr=%h wdata=%h wstrb=%h done=%b err=%b required 1 1 204 12345678 f 1 0",
               mem_en, mem_rw_mode, mem_addr, mem_wdata, mem_wstrb, st_done, st_err);
    end
    st_req = 1'b0;
    en_count = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (mem_en || st_done) en_count++;
    end
    total++;
    if (en_count !== 0) begin
      bad++;
      $display("FAIL store_after: extra_active_cycles=%0d required 0", en_count);
    end
    total++;
    if (tmem[129] !== 32'h12345678) begin
      bad++;
      $display("FAIL store_mem: word=%h required 12345678", tmem[129]);
    end
    $display("single_store: addr=204 wdata=12345678");
  endtask

  task automatic test_round_robin();
    byte who [0:7];
    int  when [0:7];
    int  n;
    byte exp_who [0:5];
    int  exp_when [0:5];
    exp_who  = '{8'h4C, 8'h53, 8'h4C, 8'h53, 8'h4C, 8'h53};
    exp_when = '{2, 4, 7, 9, 12, 14};
    n = 0;
    i_rst = 1'b0;
    ld_addr = 32'h100; ld_size = 2'b10; ld_req = 1'b1;
    st_addr = 32'h208; st_size = 2'b10; st_wdata = 32'hCAFEF00D; st_wstrb = 4'hF; st_req = 1'b1;
    @(negedge clk);
    i_rst = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (ld_done && n < 8) begin who[n] = 8'h4C; when[n] = c; n++; end
      if (st_done && n < 8) begin who[n] = 8'h53; when[n] = c; n++; end
    end
    ld_req = 1'b0; st_req = 1'b0;
    total++;
    if (n !== 6) begin
      bad++;
      $display("FAIL rr_count: grants=%0d required 6", n);
    end
    for (int i = 0; i < 6; i++) begin
      if (i < n) begin
        total++;
        if (who[i] !== exp_who[i] || when[i] !== exp_when[i]) begin
          bad++;
          $display("FAIL rr_grant%0d: got %c at cycle %0d required %c at cycle %0d",
                   i, who[i], when[i], exp_who[i], exp_when[i]);
        end
      end
    end
    repeat (4) @(negedge clk);
    $display("round_robin: grants observed=%0d", n);
  endtask

  task automatic test_reset_mid();
    ld_addr = 32'h100; ld_size = 2'b10; ld_req = 1'b1;
    @(negedge clk);
    total++;
    if (mem_en !== 1'b1) begin
      bad++;
      $display("FAIL midrst_pre: mem_en=%b required 1", mem_en);
    end
    #2 i_rst = 1'b0;
    #1;
    total++;
    if (mem_en !== 1'b0 || mem_addr !== 32'h0 || ld_done !== 1'b0 || stall_pc !== 1'b0) begin
      bad++;
      $display("FAIL midrst_async: en=%b addr=%h done=%b stall=%b required 0 0 0 0", mem_en, mem_addr, ld_done, stall_pc);
    end
    @(negedge clk);
    total++;
    if (ld_done !== 1'b0) begin
      bad++;
      $display("FAIL midrst_nodone: ld_done=%b required 0", ld_done);
    end
    i_rst = 1'b1;
    @(negedge clk);
    total++;
    if (mem_en !== 1'b1 || mem_addr !== 32'h100) begin
      bad++;
      $display("FAIL midrst_reissue: en=%b addr=%h required 1 100", mem_en, mem_addr);
    end
    @(negedge clk);
    total++;
    if (ld_done !== 1'b1 || ld_rdata !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL midrst_done: done=%b rdata=%h required 1 deadbeef", ld_done, ld_rdata);
    end
    ld_req = 1'b0;
    repeat (2) @(negedge clk);
    $display("reset_mid: load reissued after reset");
  endtask

  task automatic test_misalign();
    ld_addr = 32'h101; ld_size = 2'b01; ld_req = 1'b1;
    @(negedge clk);
`ifdef DMEM_MISALIGN_CHECK_EN
    total++;
    if (ld_done !== 1'b1 || ld_err !== 1'b1 || mem_en !== 1'b0) begin
      bad++;
      $display("FAIL mis_load: done=%b err=%b en=%b required 1 1 0", ld_done, ld_err, mem_en);
    end
    ld_req = 1'b0;
`else
    total++;
    if (mem_en !== 1'b1 || mem_addr !== 32'h101) begin
      bad++;
      $display("FAIL mis_load_pass: en=%b addr=%h required 1 101", mem_en, mem_addr);
    end
    @(negedge clk);
    total++;
    if (ld_done !== 1'b1 || ld_err !== 1'b0) begin
      bad++;
      $display("FAIL mis_load_noerr: done=%b err=%b required 1 0", ld_done, ld_err);
    end
    ld_req = 1'b0;
`endif
    repeat (2) @(negedge clk);
    st_addr = 32'h202; st_size = 2'b10; st_wdata = 32'h0; st_wstrb = 4'hF; st_req = 1'b1;
    @(negedge clk);
`ifdef DMEM_MISALIGN_CHECK_EN
    total++;
    if (st_done !== 1'b1 || st_err !== 1'b1 || mem_en !== 1'b0) begin
      bad++;
      $display("FAIL mis_store: done=%b err=%b en=%b required 1 1 0", st_done, st_err, mem_en);
    end
`else
    total++;
    if (st_done !== 1'b1 || st_err !== 1'b0 || mem_en !== 1'b1 || mem_addr !== 32'h202) begin
      bad++;
      $display("FAIL mis_store_pass: done=%b err=%b en=%b addr=%h required 1 0 1 202", st_done, st_err, mem_en, mem_addr);
    end
`endif
    st_req = 1'b0;
    repeat (2) @(negedge clk);
    $display("misalign: load half@101 store word@202 checked");
  endtask

  task automatic test_back_to_back();
    tmem[192] = 32'h11223344;
    st_addr = 32'h300; st_size = 2'b10; st_wdata = 32'hAABBCCDD; st_wstrb = 4'b0011; st_req = 1'b1;
    @(negedge clk);
    total++;
    if (mem_en !== 1'b1 || mem_rw_mode !== 1'b1 || mem_wstrb !== 4'b0011 || st_done !== 1'b1) begin
      bad++;
      $display("FAIL b2b_store: en=%b rw=%b wstrb=%b done=%b required 1 1 0011 1", mem_en, mem_rw_mode, mem_wstrb, st_done);
    end
    st_req = 1'b0;
    ld_addr = 32'h300; ld_size = 2'b10; ld_req = 1'b1;
    @(negedge clk);
    total++;
    if (mem_en !== 1'b0) begin
      bad++;
      $display("FAIL b2b_idle: mem_en=%b required 0", mem_en);
    end
    @(negedge clk);
    total++;
    if (mem_en !== 1'b1 || mem_rw_mode !== 1'b0 || mem_wstrb !== 4'b0000 || mem_addr !== 32'h300) begin
      bad++;
      $display("FAIL b2b_read: en=%b rw=%b wstrb=%b addr=%h required 1 0 0000 300", mem_en, mem_rw_mode, mem_wstrb, mem_addr);
    end
    @(negedge clk);
    total++;
    if (ld_done !== 1'b1 || ld_rdata !== 32'h1122CCDD) begin
      bad++;
      $display("FAIL b2b_rdata: done=%b rdata=%h required 1 1122ccdd", ld_done, ld_rdata);
    end
    ld_req = 1'b0;
    repeat (2) @(negedge clk);
    $display("back_to_back: store strb 0011 then load @300 rdata=%h", 32'h1122CCDD);
  endtask

  initial begin
    total = 0; bad = 0;
    i_rst = 1'b0;
    ld_req = 1'b0; ld_addr = '0; ld_size = '0;
    st_req = 1'b0; st_addr = '0; st_size = '0; st_wdata = '0; st_wstrb = '0;
    mem_rdata = '0;
    for (int i = 0; i < 256; i++) tmem[i] = 32'h0;
    @(negedge clk);
    test_reset();
    test_single_load();
    test_single_store();
    test_round_robin();
    test_reset_mid();
    test_misalign();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
